// File: rtl/codec_init_sequencer.sv
// codec_init_sequencer
// Walks a fixed 8-entry {reg_addr, data} table into a CODEC register
// controller, handshaking on controller_busy with per-wait timeouts.
// Optional build macro: CODEC_INIT_POWERUP_DELAY_EN inserts a DELAY_CYCLES
// power-up wait before entry 6.
module codec_init_sequencer #(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int DELAY_CYCLES   = 65536
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       controller_busy,
   output logic       codec_wr_en,
   output logic [7:0] codec_reg_addr,
   output logic [7:0] codec_data_wr,
   output logic       init_busy,
   output logic       init_done,
   output logic       init_error,
   output logic [2:0] entry_index
);

   // One shared wait counter covers both the handshake timeouts and the delay.
   localparam int MAX_WAIT = (TIMEOUT_CYCLES > DELAY_CYCLES) ? TIMEOUT_CYCLES : DELAY_CYCLES;
   localparam int CNT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`ifdef CODEC_INIT_POWERUP_DELAY_EN
   localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(DELAY_CYCLES - 1);
`endif

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_ISSUE     = 3'd1;
   localparam logic [2:0] S_WAIT_BUSY = 3'd2;
   localparam logic [2:0] S_WAIT_DONE = 3'd3;
`ifdef CODEC_INIT_POWERUP_DELAY_EN
   localparam logic [2:0] S_DELAY     = 3'd4;
`endif
   localparam logic [2:0] S_DONE      = 3'd5;
   localparam logic [2:0] S_ERROR     = 3'd6;

   logic [2:0]       state_reg;
   logic [CNT_W-1:0] wait_cnt_reg;
   logic             start_prev_reg;
   logic             start_edge;
   logic [7:0]       tbl_addr;
   logic [7:0]       tbl_data;

   assign start_edge = start & ~start_prev_reg;

   // Fixed init table, looked up by the current entry index.
   always_comb begin
      tbl_addr = 8'h00;
      tbl_data = 8'h00;
      case (entry_index)
         3'd0: begin tbl_addr = 8'h1E; tbl_data = 8'h00; end // reset
         3'd1: begin tbl_addr = 8'h0C; tbl_data = 8'h10; end // power
         3'd2: begin tbl_addr = 8'h08; tbl_data = 8'h10; end // analog path
         3'd3: begin tbl_addr = 8'h0A; tbl_data = 8'h00; end // digital path
         3'd4: begin tbl_addr = 8'h0E; tbl_data = 8'h02; end // I2S 16-bit
         3'd5: begin tbl_addr = 8'h10; tbl_data = 8'h00; end // sample rate
         3'd6: begin tbl_addr = 8'h12; tbl_data = 8'h01; end // active
         default: begin tbl_addr = 8'h0C; tbl_data = 8'h00; end // output power-up
      endcase
   end

   // Sequencer FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= S_IDLE;
         wait_cnt_reg   <= '0;
         start_prev_reg <= 1'b1;   // a start already high at release is not an edge
         codec_wr_en    <= 1'b0;
         codec_reg_addr <= 8'h00;
         codec_data_wr  <= 8'h00;
         init_busy      <= 1'b0;
         init_done      <= 1'b0;
         init_error     <= 1'b0;
         entry_index    <= 3'd0;
      end else begin
         start_prev_reg <= start;
         codec_wr_en    <= 1'b0;
         case (state_reg)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start_edge) begin
                  state_reg    <= S_ISSUE;
                  wait_cnt_reg <= '0;
                  entry_index  <= 3'd0;
                  init_done    <= 1'b0;
                  init_error   <= 1'b0;
                  init_busy    <= 1'b1;
               end
            end
            S_ISSUE: begin
               // Address/data are only loaded here, so they hold until the next issue.
               codec_wr_en    <= 1'b1;
               codec_reg_addr <= tbl_addr;
               codec_data_wr  <= tbl_data;
               state_reg      <= S_WAIT_BUSY;
               wait_cnt_reg   <= '0;
            end
            S_WAIT_BUSY: begin
               if (controller_busy) begin
                  state_reg    <= S_WAIT_DONE;
                  wait_cnt_reg <= '0;
               end else if (wait_cnt_reg == TIMEOUT_LAST) begin
                  state_reg    <= S_ERROR;
                  wait_cnt_reg <= '0;
                  init_error   <= 1'b1;
                  init_busy    <= 1'b0;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
               end
            end
            S_WAIT_DONE: begin
               if (!controller_busy) begin
                  wait_cnt_reg <= '0;
                  if (entry_index == 3'd7) begin
                     state_reg <= S_DONE;
                     init_done <= 1'b1;
                     init_busy <= 1'b0;
`ifdef CODEC_INIT_POWERUP_DELAY_EN
                  end else if (entry_index == 3'd5) begin
                     state_reg   <= S_DELAY;
                     entry_index <= 3'd6;
`endif
                  end else begin
                     state_reg   <= S_ISSUE;
                     entry_index <= entry_index + 3'd1;
                  end
               end else if (wait_cnt_reg == TIMEOUT_LAST) begin
                  state_reg    <= S_ERROR;
                  wait_cnt_reg <= '0;
                  init_error   <= 1'b1;
                  init_busy    <= 1'b0;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
               end
            end
`ifdef CODEC_INIT_POWERUP_DELAY_EN
            S_DELAY: begin
               if (wait_cnt_reg == DELAY_LAST) begin
                  state_reg    <= S_ISSUE;
                  wait_cnt_reg <= '0;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
               end
            end
`endif
            default: begin
               state_reg    <= S_IDLE;
               wait_cnt_reg <= '0;
               init_busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/codec_init_sequencer.md
CODEC_INIT_SEQUENCER -- requirements
Module: codec_init_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096: maximum cycles spent in any single wait state.
REQ-002 SHALL have parameter DELAY_CYCLES, default 65536: power-up wait before entry 6, used only when CODEC_INIT_POWERUP_DELAY_EN is defined.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: a rising edge starts the init sequence.
REQ-006 SHALL have port controller_busy, input, 1: busy status from the downstream CODEC register controller.
REQ-007 SHALL have port codec_wr_en, output, 1: one-cycle write request to the controller.
REQ-008 SHALL have port codec_reg_addr, output, 8: CODEC register address byte.
REQ-009 SHALL have port codec_data_wr, output, 8: CODEC write data byte.
REQ-010 SHALL have port init_busy, output, 1: high while the sequence runs.
REQ-011 SHALL have port init_done, output, 1: sticky; high after all entries complete.
REQ-012 SHALL have port init_error, output, 1: sticky; high after any timeout.
REQ-013 SHALL have port entry_index, output, 3: index of the current or last table entry.

Function
REQ-014 SHALL hold a fixed 8-entry table of {reg_addr, data} pairs:
- 0 {0x1E,0x00} reset
- 1 {0x0C,0x10} power
- 2 {0x08,0x10} analog path
- 3 {0x0A,0x00} digital path
- 4 {0x0E,0x02} I2S 16-bit
- 5 {0x10,0x00} sample rate
- 6 {0x12,0x01} active
- 7 {0x0C,0x00} output power-up
REQ-015 SHALL implement the states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DELAY, DONE and ERROR.
REQ-016 SHALL detect start on a rising edge using a registered previous value; a held-high start SHALL NOT retrigger.
REQ-017 IDLE/DONE/ERROR + start edge -> ISSUE with entry_index=0; init_done and init_error clear in the same cycle.
REQ-018 A start edge in ISSUE, WAIT_BUSY, WAIT_DONE or DELAY SHALL be ignored.
REQ-019 ISSUE: codec_wr_en=1 for exactly one cycle with the table entry on codec_reg_addr/codec_data_wr -> WAIT_BUSY.
REQ-020 codec_reg_addr/codec_data_wr SHALL stay stable from ISSUE until the next ISSUE.
REQ-021 WAIT_BUSY: controller_busy=1 -> WAIT_DONE; TIMEOUT_CYCLES elapsed without busy -> ERROR.
REQ-022 WAIT_DONE: controller_busy=0 -> advance:
- entry 7 -> DONE
- next entry 6 with the delay feature compiled in -> DELAY
- otherwise entry_index+1 -> ISSUE
REQ-023 WAIT_DONE: TIMEOUT_CYCLES elapsed with busy still high -> ERROR.
REQ-024 A single wait counter, zeroed on every state entry, SHALL time every wait; its width SHALL be sized for max(TIMEOUT_CYCLES, DELAY_CYCLES).
REQ-025 A timeout SHALL fire on the cycle the count reaches TIMEOUT_CYCLES-1.
REQ-026 DELAY: exactly DELAY_CYCLES cycles, then ISSUE entry 6.
REQ-027 DONE: init_done=1, init_busy=0.
REQ-028 ERROR: init_error=1, init_busy=0, entry_index frozen at the failing entry.
REQ-029 init_busy SHALL be 1 in ISSUE, WAIT_BUSY, WAIT_DONE and DELAY, and 0 otherwise.
REQ-030 Outputs SHALL be registered; codec_wr_en SHALL assert on the cycle after the state enters ISSUE.
REQ-031 Minimum latency from start edge to the first codec_wr_en SHALL be 2 cycles.

Reset
REQ-032 Asserting reset SHALL immediately force state IDLE, all outputs 0, entry_index=0 and the wait counter to 0.
REQ-033 Reset mid-sequence SHALL abandon the sequence; the sequence SHALL NOT resume after reset release.
REQ-034 The start edge detector SHALL reset its previous value to 1, so a start already high at reset release does not trigger.

Configuration
REQ-035 CODEC_INIT_POWERUP_DELAY_EN defined: the DELAY state and DELAY_CYCLES SHALL be active before entry 6.
REQ-036 CODEC_INIT_POWERUP_DELAY_EN undefined: the DELAY state SHALL be absent and entry 6 SHALL issue directly after entry 5 completes.

Verification
REQ-037 Nominal: start pulse; model busy high 3 cycles after each wr_en for 10 cycles -> 8 wr_en pulses in table order, init_done=1, init_error=0.
REQ-038 Delay (macro defined, DELAY_CYCLES=100): gap from entry-5 busy fall to entry-6 wr_en = 101 cycles ±1 -> init_done=1.
REQ-039 Busy never asserts (TIMEOUT_CYCLES=16) -> init_error=1 16 cycles after the first wr_en; entry_index=0; no further wr_en.
REQ-040 Busy stuck high after entry 3 -> init_error=1, entry_index=3; a new start edge restarts from entry 0 and clears init_error.
REQ-041 Reset asserted during entry 4 WAIT_DONE, start held high through release -> outputs 0 and no wr_en until start toggles 0->1.
REQ-042 Start re-pulsed during entry 2 -> ignored; exactly 8 wr_en pulses total.
